// File: rtl/seg_sched_if.sv
// Segment command channel between seg_sched and the downstream line-draw engine.
interface seg_sched_if;
  logic        seg_valid;
  logic        seg_ready;
  logic [9:0]  seg_x0;
  logic [9:0]  seg_y0;
  logic [9:0]  seg_x1;
  logic [9:0]  seg_y1;
  logic [11:0] seg_color;

  modport master (output seg_valid, seg_x0, seg_y0, seg_x1, seg_y1, seg_color,
                  input  seg_ready);
  modport slave  (input  seg_valid, seg_x0, seg_y0, seg_x1, seg_y1, seg_color,
                  output seg_ready);
endinterface

// File: rtl/seg_sched.sv
// Pose-frame scheduler: synchronises the SPI frame-done level, validates and queues
// frames, then issues each frame as point-to-point line segments over valid/ready.
module seg_sched #(
  parameter  int unsigned X_MAX      = 640,
  parameter  int unsigned Y_MAX      = 480,
  parameter  int unsigned FIFO_DEPTH = 4,
  parameter  int unsigned CLOSED     = 1,
  localparam int unsigned FRAME_W    = 92
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_done,
  input  logic [FRAME_W-1:0] frame_data,
  seg_sched_if.master        seg,
  output logic               busy,
  output logic               frame_drop,
  output logic               bad_frame,
  output logic [7:0]         frame_count
);
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned COLOR_W  = 12;
  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam logic [1:0]  LAST_IDX = (CLOSED != 0) ? 2'd3 : 2'd2;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_e;

  // Point k (0..3) fields; x_1 sits at the MSB end of the frame word.
  function automatic logic [COORD_W-1:0] pt_x(input logic [FRAME_W-1:0] f, input int unsigned k);
    return COORD_W'(f >> (FRAME_W - COORD_W - 2 * COORD_W * k));
  endfunction

  function automatic logic [COORD_W-1:0] pt_y(input logic [FRAME_W-1:0] f, input int unsigned k);
    return COORD_W'(f >> (FRAME_W - 2 * COORD_W - 2 * COORD_W * k));
  endfunction

  function automatic logic coords_ok(input logic [FRAME_W-1:0] f);
    logic ok;
    ok = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      if (32'(pt_x(f, k)) >= X_MAX || 32'(pt_y(f, k)) >= Y_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

  // Done-level synchroniser; fill flops keep the reset-cleared s2 from arming.
  logic s1_q, s2_q, s3_q, fill1_q, fill2_q, arm_q;
  logic rise_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      fill1_q <= 1'b0;
      fill2_q <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      s1_q    <= frame_done;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      fill1_q <= 1'b1;
      fill2_q <= fill1_q;
      if (fill2_q && !s2_q) arm_q <= 1'b1;
    end
  end

  assign rise_c = s2_q & ~s3_q & arm_q;

  // Frame queue
  logic [FRAME_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] head_c;
  logic               frame_ok_c, pop_c, push_c, drop_c, bad_c;
  state_e             state_q, state_d;

  assign head_c     = mem_q[rd_ptr_q];
  assign frame_ok_c = coords_ok(frame_data);
  assign pop_c      = (state_q == FETCH);
  assign bad_c      = rise_c & ~frame_ok_c;
  assign push_c     = rise_c & frame_ok_c & ((cnt_q != FULL) | pop_c);
  assign drop_c     = rise_c & frame_ok_c & (cnt_q == FULL) & ~pop_c;
  assign cnt_d      = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= frame_data;
  end

  // Segment sequencer
  logic [1:0]         idx_q, idx_d, nidx_c, eidx_c;
  logic [COORD_W-1:0] px_q [4];
  logic [COORD_W-1:0] py_q [4];
  logic [COORD_W-1:0] px_d [4];
  logic [COORD_W-1:0] py_d [4];
  logic [COORD_W-1:0] sx0_q, sy0_q, sx1_q, sy1_q, sx0_d, sy0_d, sx1_d, sy1_d;
  logic [COLOR_W-1:0] scol_q, scol_d;
  logic               valid_q, valid_d, busy_q, busy_d;
  logic [7:0]         fcnt_q, fcnt_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    px_d    = px_q;
    py_d    = py_q;
    sx0_d   = sx0_q;
    sy0_d   = sy0_q;
    sx1_d   = sx1_q;
    sy1_d   = sy1_q;
    scol_d  = scol_q;
    valid_d = valid_q;
    fcnt_d  = fcnt_q;
    nidx_c  = idx_q + 2'd1;
    eidx_c  = nidx_c + 2'd1;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) state_d = FETCH;
      end
      FETCH: begin
        for (int unsigned k = 0; k < 4; k++) begin
          px_d[k] = pt_x(head_c, k);
          py_d[k] = pt_y(head_c, k);
        end
        idx_d   = 2'd0;
        sx0_d   = pt_x(head_c, 0);
        sy0_d   = pt_y(head_c, 0);
        sx1_d   = pt_x(head_c, 1);
        sy1_d   = pt_y(head_c, 1);
        scol_d  = head_c[COLOR_W-1:0];
        valid_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (valid_q && seg.seg_ready) begin
          if (idx_q != LAST_IDX) begin
            // eidx wraps 3 -> 0, giving the closing p4 -> p1 segment
            idx_d = nidx_c;
            sx0_d = px_q[nidx_c];
            sy0_d = py_q[nidx_c];
            sx1_d = px_q[eidx_c];
            sy1_d = py_q[eidx_c];
          end else begin
            fcnt_d  = fcnt_q + 8'd1;
            valid_d = 1'b0;
            state_d = (cnt_q != '0) ? FETCH : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) | (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      for (int unsigned k = 0; k < 4; k++) begin
        px_q[k] <= '0;
        py_q[k] <= '0;
      end
      sx0_q      <= '0;
      sy0_q      <= '0;
      sx1_q      <= '0;
      sy1_q      <= '0;
      scol_q     <= '0;
      valid_q    <= 1'b0;
      fcnt_q     <= 8'd0;
      busy_q     <= 1'b0;
      frame_drop <= 1'b0;
      bad_frame  <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      px_q       <= px_d;
      py_q       <= py_d;
      sx0_q      <= sx0_d;
      sy0_q      <= sy0_d;
      sx1_q      <= sx1_d;
      sy1_q      <= sy1_d;
      scol_q     <= scol_d;
      valid_q    <= valid_d;
      fcnt_q     <= fcnt_d;
      busy_q     <= busy_d;
      frame_drop <= drop_c;
      bad_frame  <= bad_c;
    end
  end

  assign seg.seg_valid = valid_q;
  assign seg.seg_x0    = sx0_q;
  assign seg.seg_y0    = sy0_q;
  assign seg.seg_x1    = sx1_q;
  assign seg.seg_y1    = sy1_q;
  assign seg.seg_color = scol_q;
  assign busy          = busy_q;
  assign frame_count   = fcnt_q;
endmodule

// File: tb/tb_seg_sched.sv
// Bench for seg_sched: a closed-polygon instance and an open (3-segment) instance,
// checked against a frame-level segment model.
module tb_seg_sched;
  localparam int FW = 92;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fd1, fd0;
  logic [FW-1:0] fdat1, fdat0;
  logic          busy1, drop1, bad1, busy0, drop0, bad0;
  logic [7:0]    fc1, fc0;

  seg_sched_if bus1 ();
  seg_sched_if bus0 ();

  seg_sched #(.CLOSED(1)) dut (
    .clk(clk), .reset_n(reset_n), .frame_done(fd1), .frame_data(fdat1), .seg(bus1),
    .busy(busy1), .frame_drop(drop1), .bad_frame(bad1), .frame_count(fc1));

  seg_sched #(.CLOSED(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .frame_done(fd0), .frame_data(fdat0), .seg(bus0),
    .busy(busy0), .frame_drop(drop0), .bad_frame(bad0), .frame_count(fc0));

  always #5 clk = ~clk;

  int total, bad_n;
  int xfer1, xfer0, drops1, bads1, drops0, bads0;
  int rmode1;
  int rcnt;
  logic [51:0] exp1[$];
  logic [51:0] exp0[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad_n++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int x1, input int y1, input int x2, input int y2,
                                       input int x3, input int y3, input int x4, input int y4,
                                       input int r, input int g, input int b);
    return {10'(x1), 10'(y1), 10'(x2), 10'(y2), 10'(x3), 10'(y3), 10'(x4), 10'(y4),
            4'(r), 4'(g), 4'(b)};
  endfunction

  function automatic logic [FW-1:0] rnd_frame(input bit make_bad);
    int xs[4];
    int ys[4];
    int k;
    for (int i = 0; i < 4; i++) begin
      xs[i] = int'($urandom_range(639));
      ys[i] = int'($urandom_range(479));
    end
    if (make_bad) begin
      k = int'($urandom_range(3));
      if ($urandom_range(1) == 1) xs[k] = int'($urandom_range(1023, 640));
      else                        ys[k] = int'($urandom_range(1023, 480));
    end
    return mk(xs[0], ys[0], xs[1], ys[1], xs[2], ys[2], xs[3], ys[3],
              int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)));
  endfunction

  // Reference: a frame becomes a list of segments p[s] -> p[(s+1) mod 4]
  task automatic expect_frame(input int which, input logic [FW-1:0] f);
    logic [9:0]    xs[4];
    logic [9:0]    ys[4];
    logic [FW-1:0] t;
    int            nseg;
    nseg = (which == 1) ? 4 : 3;
    for (int k = 0; k < 4; k++) begin
      t = f >> (FW - 10 - 20 * k);
      xs[k] = t[9:0];
      t = f >> (FW - 20 - 20 * k);
      ys[k] = t[9:0];
    end
    for (int s = 0; s < nseg; s++) begin
      if (which == 1) exp1.push_back({xs[s], ys[s], xs[(s + 1) % 4], ys[(s + 1) % 4], f[11:0]});
      else            exp0.push_back({xs[s], ys[s], xs[(s + 1) % 4], ys[(s + 1) % 4], f[11:0]});
    end
  endtask

  task automatic send(input int which, input logic [FW-1:0] f);
    @(posedge clk); #1;
    if (which == 1) begin fdat1 = f; fd1 = 1'b1; end
    else            begin fdat0 = f; fd0 = 1'b1; end
    repeat (4) @(posedge clk);
    #1;
    if (which == 1) fd1 = 1'b0; else fd0 = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic drain(input int which, input int budget, input string tag);
    int n;
    n = 0;
    if (which == 1) begin
      while ((exp1.size() != 0 || busy1) && n < budget) begin @(posedge clk); n++; end
    end else begin
      while ((exp0.size() != 0 || busy0) && n < budget) begin @(posedge clk); n++; end
    end
    @(negedge clk);
    chk({tag, "_drained"}, 64'((which == 1) ? exp1.size() : exp0.size()), 64'(0));
    chk({tag, "_idle"}, 64'((which == 1) ? busy1 : busy0), 64'(0));
  endtask

  // seg_ready driver for the closed instance
  initial forever begin
    @(posedge clk); #1;
    case (rmode1)
      0:       bus1.seg_ready = 1'b0;
      1:       bus1.seg_ready = 1'b1;
      2:       bus1.seg_ready = ($urandom_range(1) == 1);
      default: begin bus1.seg_ready = (rcnt % 3 == 2); rcnt++; end
    endcase
  end

  // Transfer monitor: scoreboard order, hold-while-stalled, pulse counters
  initial begin
    logic [51:0] cur1, prev1, cur0;
    logic        pend1;
    pend1 = 1'b0;
    prev1 = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend1 = 1'b0;
      end else begin
        cur1 = {bus1.seg_x0, bus1.seg_y0, bus1.seg_x1, bus1.seg_y1, bus1.seg_color};
        cur0 = {bus0.seg_x0, bus0.seg_y0, bus0.seg_x1, bus0.seg_y1, bus0.seg_color};
        if (pend1) begin
          chk("hold_valid", 64'(bus1.seg_valid), 64'(1));
          chk("hold_payload", 64'(cur1), 64'(prev1));
        end
        if (bus1.seg_valid && bus1.seg_ready) begin
          xfer1++;
          chk("seg1_expected", 64'(exp1.size() != 0), 64'(1));
          if (exp1.size() != 0) chk("seg1", 64'(cur1), 64'(exp1.pop_front()));
        end
        if (bus0.seg_valid && bus0.seg_ready) begin
          xfer0++;
          chk("seg0_expected", 64'(exp0.size() != 0), 64'(1));
          if (exp0.size() != 0) chk("seg0", 64'(cur0), 64'(exp0.pop_front()));
        end
        pend1 = bus1.seg_valid & ~bus1.seg_ready;
        prev1 = cur1;
        if (drop1) drops1++;
        if (bad1)  bads1++;
        if (drop0) drops0++;
        if (bad0)  bads0++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] f;
    int x0, d0, b0, nvalid, nbad, n;
    logic isbad;
    total = 0; bad_n = 0;
    xfer1 = 0; xfer0 = 0; drops1 = 0; bads1 = 0; drops0 = 0; bads0 = 0;
    rmode1 = 1; rcnt = 0;
    reset_n = 1'b0; fd1 = 1'b0; fd0 = 1'b0; fdat1 = '0; fdat0 = '0;
    bus0.seg_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    chk("rst_valid", 64'(bus1.seg_valid), 64'(0));
    chk("rst_busy", 64'(busy1), 64'(0));
    chk("rst_fc", 64'(fc1), 64'(0));
    chk("rst_drop", 64'(drop1), 64'(0));
    chk("rst_bad", 64'(bad1), 64'(0));
    chk("rst_payload", 64'({bus1.seg_x0, bus1.seg_y0, bus1.seg_x1, bus1.seg_y1, bus1.seg_color}), 64'(0));
    repeat (4) @(posedge clk);

    // Square frame: latency and segment order
    f = mk(10, 20, 100, 20, 100, 200, 10, 200, 15, 0, 0);
    expect_frame(1, f);
    x0 = xfer1;
    @(posedge clk); #1; fdat1 = f; fd1 = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 chk("lat_n3_valid", 64'(bus1.seg_valid), 64'(0));
    @(posedge clk);
    #1 chk("lat_n4_valid", 64'(bus1.seg_valid), 64'(1));
    chk("first_seg", 64'({bus1.seg_x0, bus1.seg_y0, bus1.seg_x1, bus1.seg_y1}), 64'({10'd10, 10'd20, 10'd100, 10'd20}));
    chk("first_color", 64'(bus1.seg_color), 64'(12'hF00));
    repeat (2) @(posedge clk);
    #1 fd1 = 1'b0;
    drain(1, 50, "t1");
    chk("t1_xfers", 64'(xfer1 - x0), 64'(4));
    chk("t1_fc", 64'(fc1), 64'(1));

    // Backpressure 0,0,1
    rmode1 = 3; rcnt = 0; x0 = xfer1;
    f = rnd_frame(1'b0);
    expect_frame(1, f);
    send(1, f);
    drain(1, 200, "t2");
    chk("t2_xfers", 64'(xfer1 - x0), 64'(4));
    chk("t2_fc", 64'(fc1), 64'(2));

    // Coordinate range boundaries
    rmode1 = 1; x0 = xfer1; b0 = bads1;
    send(1, mk(10, 20, 640, 20, 100, 200, 10, 200, 1, 2, 3));
    send(1, mk(10, 20, 100, 20, 100, 200, 10, 480, 1, 2, 3));
    repeat (4) @(posedge clk);
    #1;
    chk("t3_bad_pulses", 64'(bads1 - b0), 64'(2));
    chk("t3_noseg", 64'(xfer1 - x0), 64'(0));
    chk("t3_busy", 64'(busy1), 64'(0));
    chk("t3_fc", 64'(fc1), 64'(2));
    f = mk(10, 20, 639, 20, 100, 200, 10, 479, 1, 2, 3);
    expect_frame(1, f);
    send(1, f);
    drain(1, 50, "t3");
    chk("t3_fc_ok", 64'(fc1), 64'(3));

    // Overflow: one in working registers, four queued, sixth dropped
    rmode1 = 0; d0 = drops1; x0 = xfer1;
    for (int i = 0; i < 6; i++) begin
      f = rnd_frame(1'b0);
      if (i < 5) expect_frame(1, f);
      send(1, f);
    end
    #1;
    chk("t4_drops", 64'(drops1 - d0), 64'(1));
    chk("t4_busy", 64'(busy1), 64'(1));
    chk("t4_stalled", 64'(xfer1 - x0), 64'(0));
    rmode1 = 1;
    drain(1, 200, "t4");
    chk("t4_xfers", 64'(xfer1 - x0), 64'(20));
    chk("t4_fc", 64'(fc1), 64'(8));

    // Reset in ISSUE at idx 2 with two frames queued
    rmode1 = 0;
    for (int i = 0; i < 3; i++) begin
      f = rnd_frame(1'b0);
      expect_frame(1, f);
      send(1, f);
    end
    x0 = xfer1;
    @(posedge clk); #2 rmode1 = 1;
    @(posedge clk);
    @(posedge clk); #2 rmode1 = 0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    fd1 = 1'b1;
    #1;
    chk("t5_xfers_before", 64'(xfer1 - x0), 64'(2));
    chk("t5_valid", 64'(bus1.seg_valid), 64'(0));
    chk("t5_busy", 64'(busy1), 64'(0));
    chk("t5_fc", 64'(fc1), 64'(0));
    exp1.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    rmode1 = 1; x0 = xfer1;
    repeat (12) @(posedge clk);
    #1;
    chk("t5_held_high_busy", 64'(busy1), 64'(0));
    chk("t5_held_high_noseg", 64'(xfer1 - x0), 64'(0));
    fd1 = 1'b0;
    repeat (3) @(posedge clk);
    f = rnd_frame(1'b0);
    expect_frame(1, f);
    send(1, f);
    drain(1, 50, "t5");
    chk("t5_fc_after", 64'(fc1), 64'(1));

    // Random frames with random backpressure
    rmode1 = 2; d0 = drops1; b0 = bads1; nvalid = 0; nbad = 0;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while ((exp1.size() + 3) / 4 > 3 && n < 500) begin @(posedge clk); n++; end
      if (n >= 500) chk("t6_backlog", 64'((exp1.size() + 3) / 4), 64'(3));
      isbad = ($urandom_range(5) == 0);
      f = rnd_frame(isbad);
      if (isbad) nbad++;
      else begin nvalid++; expect_frame(1, f); end
      send(1, f);
    end
    drain(1, 2000, "t6");
    chk("t6_drops", 64'(drops1 - d0), 64'(0));
    chk("t6_bads", 64'(bads1 - b0), 64'(nbad));
    chk("t6_fc", 64'(fc1), 64'(8'(1 + nvalid)));

    // Open polygon instance: 256 frames, counter wraps
    x0 = xfer0;
    for (int i = 0; i < 256; i++) begin
      f = rnd_frame(1'b0);
      expect_frame(0, f);
      send(0, f);
      if (i == 127) begin
        drain(0, 100, "t7_mid");
        chk("t7_fc_mid", 64'(fc0), 64'(128));
      end
    end
    drain(0, 200, "t7");
    chk("t7_xfers", 64'(xfer0 - x0), 64'(768));
    chk("t7_fc_wrap", 64'(fc0), 64'(0));
    chk("t7_drops", 64'(drops0), 64'(0));
    chk("t7_bads", 64'(bads0), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end
endmodule
